register_stack: RTL and testbench



---
 rtl/register_stack.sv | 93 +++++++++
 tb/tb_register_stack.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/register_stack.sv
// LIFO operand stack for the RegisterStack CPU: push/pop/replace with TOS/NOS
// exposed from registered state, occupancy count and sticky overflow/underflow.
module register_stack #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic [DATA_WIDTH-1:0] in_input_value,
  input  logic                  in_push,
  input  logic                  in_pop,
  input  logic                  in_clear_err,
  output logic [DATA_WIDTH-1:0] ot_top,
  output logic [DATA_WIDTH-1:0] ot_next,
  output logic [CW-1:0]         ot_count,
  output logic                  ot_empty,
  output logic                  ot_full,
  output logic                  ot_overflow,
  output logic                  ot_underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         count, count_nxt;
  logic                  overflow, underflow;
  logic                  wr_en, ovf_set, unf_set;
  logic [AW-1:0]         wr_idx;

  assign ot_empty = (count == '0);
  assign ot_full  = (count == CW'(DEPTH));

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = AW'(count);
    count_nxt = count;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    unique case ({in_push, in_pop})
      2'b10: begin
        if (!ot_full) begin
          wr_en     = 1'b1;
          count_nxt = count + CW'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
      2'b01: begin
        if (!ot_empty) count_nxt = count - CW'(1);
        else           unf_set   = 1'b1;
      end
      2'b11: begin
        wr_en = 1'b1;
        if (!ot_empty) begin
          wr_idx = AW'(count - CW'(1));
        end else begin
          // Replace on an empty stack still pushes, but reports the missing pop.
          wr_idx    = '0;
          count_nxt = CW'(1);
          unf_set   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      overflow  <= ovf_set | (overflow  & ~in_clear_err);
      underflow <= unf_set | (underflow & ~in_clear_err);
    end
  end

  // NOTE: storage is deliberately not reset; stale words are hidden by the count-gated outputs.
  always_ff @(posedge in_clk) begin
    if (wr_en) mem[wr_idx] <= in_input_value;
  end

  assign ot_top       = (count >= CW'(1)) ? mem[AW'(count - CW'(1))] : '0;
  assign ot_next      = (count >= CW'(2)) ? mem[AW'(count - CW'(2))] : '0;
  assign ot_count     = count;
  assign ot_overflow  = overflow;
  assign ot_underflow = underflow;

endmodule

// File: tb/tb_register_stack.sv
// Self-checking bench for register_stack (DEPTH=4): directed vector table,
// asynchronous reset sequence, and randomized traffic against a queue model.
module tb_register_stack;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] value = '0;
  logic          push = 1'b0, pop = 1'b0, clr = 1'b0;
  logic [DW-1:0] top, nxt;
  logic [CW-1:0] count;
  logic          empty, full, overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  register_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .in_clk         (clk),
    .in_reset       (rst),
    .in_input_value (value),
    .in_push        (push),
    .in_pop         (pop),
    .in_clear_err   (clr),
    .ot_top         (top),
    .ot_next        (nxt),
    .ot_count       (count),
    .ot_empty       (empty),
    .ot_full        (full),
    .ot_overflow    (overflow),
    .ot_underflow   (underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue whose back is the top of stack, plus two flags.
  logic [DW-1:0] q[$];
  logic          m_ovf, m_unf;

  typedef struct {
    logic          push, pop, clr;
    logic [DW-1:0] val, top, nxt;
    int            cnt;
    logic          ovf, unf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic o, input logic c, input logic [DW-1:0] v);
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (p && o) begin
      if (q.size() == 0) begin
        q.push_back(v);
        m_unf = 1'b1;
      end else begin
        q[q.size()-1] = v;
      end
    end else if (p) begin
      if (q.size() < DEPTH) q.push_back(v);
      else                  m_ovf = 1'b1;
    end else if (o) begin
      if (q.size() > 0) void'(q.pop_back());
      else              m_unf = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    logic [DW-1:0] e_top, e_nxt;
    e_top = (q.size() > 0) ? q[q.size()-1] : '0;
    e_nxt = (q.size() > 1) ? q[q.size()-2] : '0;
    check({tag, ".top"},   32'(top),       32'(e_top));
    check({tag, ".next"},  32'(nxt),       32'(e_nxt));
    check({tag, ".count"}, 32'(count),     32'(q.size()));
    check({tag, ".empty"}, 32'(empty),     32'(q.size() == 0));
    check({tag, ".full"},  32'(full),      32'(q.size() == DEPTH));
    check({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    check({tag, ".unf"},   32'(underflow), 32'(m_unf));
  endtask

  task automatic drive(input logic p, input logic o, input logic c, input logic [DW-1:0] v);
    push  = p;
    pop   = o;
    clr   = c;
    value = v;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // push pop clr val top next cnt ovf unf
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'hABCD, 16'hABCD, 16'h0000, 1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h1234, 16'h1234, 16'hABCD, 2, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 16'hCCCC, 16'hCCCC, 16'hABCD, 2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h0000, 16'hABCD, 16'h0000, 1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 16'h5678, 16'h5678, 16'h0000, 1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h0000, 16'h5678, 16'h0000, 1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h0002, 16'h0002, 16'h5678, 2, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h0003, 16'h0003, 16'h0002, 3, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h0004, 16'h0004, 16'h0003, 4, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h0005, 16'h0004, 16'h0003, 4, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 16'h0009, 16'h0009, 16'h0003, 4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0003, 16'h0002, 3, 1'b1, 1'b0});

    #7;
    check("reset.count", 32'(count), 32'd0);
    check("reset.top",   32'(top),   32'd0);
    check("reset.empty", 32'(empty), 32'd1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].val);
      check({tag, ".top"},   32'(top),       32'(vecs[i].top));
      check({tag, ".next"},  32'(nxt),       32'(vecs[i].nxt));
      check({tag, ".count"}, 32'(count),     32'(vecs[i].cnt));
      check({tag, ".empty"}, 32'(empty),     32'(vecs[i].cnt == 0));
      check({tag, ".full"},  32'(full),      32'(vecs[i].cnt == DEPTH));
      check({tag, ".ovf"},   32'(overflow),  32'(vecs[i].ovf));
      check({tag, ".unf"},   32'(underflow), 32'(vecs[i].unf));
    end

    // Asynchronous reset between edges with count=3 and a push pending.
    @(negedge clk);
    push  = 1'b1;
    value = 16'hCDEF;
    rst   = 1'b1;
    #1;
    check("areset.count", 32'(count),     32'd0);
    check("areset.top",   32'(top),       32'd0);
    check("areset.next",  32'(nxt),       32'd0);
    check("areset.empty", 32'(empty),     32'd1);
    check("areset.ovf",   32'(overflow),  32'd0);
    check("areset.unf",   32'(underflow), 32'd0);
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'hCDEF);
    check("post_reset.top",   32'(top),   32'hCDEF);
    check("post_reset.count", 32'(count), 32'd1);

    // Replace on a full stack of known contents, then randomized traffic.
    do_reset();
    model_reset();
    check_model("rst2");
    for (int i = 0; i < DEPTH; i++) begin
      logic [DW-1:0] v;
      v = (i == 0) ? 16'hAAAA : 16'hBBBB + DW'(i);
      model_step(1'b1, 1'b0, 1'b0, v);
      drive(1'b1, 1'b0, 1'b0, v);
    end
    model_step(1'b1, 1'b1, 1'b0, 16'hCCCC);
    drive(1'b1, 1'b1, 1'b0, 16'hCCCC);
    check_model("full_replace");

    for (int i = 0; i < 600; i++) begin
      logic          p, o, c;
      logic [DW-1:0] v;
      int            bias;
      bias = ((i / 50) % 2 == 0) ? 70 : 30;
      p = ($urandom_range(0, 99) < bias);
      o = ($urandom_range(0, 99) < (100 - bias));
      c = ($urandom_range(0, 9) == 0);
      v = DW'($urandom);
      model_step(p, o, c, v);
      drive(p, o, c, v);
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
